// File: rtl/fifo_read_arbiter.sv
// Round-robin arbiter sharing the FIFO read port among NUM_REQ read-domain consumers.
// Grants bounded bursts and steers each returned word back to its owner with a one-hot valid.
module fifo_read_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  r_clk,
  input  logic                  rrst,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_req,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic                  busy
);

  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned IdxW1 = IdxW + 1;
  localparam int unsigned CntW  = $clog2(BURST_LEN + 1);

  typedef enum logic {StIdle = 1'b0, StBurst = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0] rvalid_d, rvalid_q;

  logic               pick_found;
  logic [IdxW-1:0]    pick_idx;
  logic [IdxW1-1:0]   cand_sum;
  logic [IdxW-1:0]    cand;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand       = '0;

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, ptr_q} + IdxW1'(i);
      cand     = IdxW'((cand_sum >= IdxW1'(NUM_REQ)) ? cand_sum - IdxW1'(NUM_REQ) : cand_sum);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end

    fifo_rd_req = (state_q == StBurst) && req[owner_q] && !fifo_empty && !rrst;
    rvalid_d    = fifo_rd_req ? gnt_q : '0;

    unique case (state_q)
      StIdle: begin
        if (pick_found && !fifo_empty) begin
          state_d = StBurst;
          owner_d = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          cnt_d   = '0;
        end
      end
      StBurst: begin
        if (fifo_rd_req) begin
          cnt_d = cnt_q + CntW'(1);
        end
        // A stalled cycle (owner dropped or FIFO empty) ends the burst without a read.
        if (!fifo_rd_req || cnt_q == CntW'(BURST_LEN - 1)) begin
          state_d = StIdle;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (rrst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign busy   = (state_q == StBurst);
  assign rdata  = fifo_rdata;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model built on a word queue and integer owner/pointer bookkeeping.
module tb_fifo_read_arbiter;

  localparam int NReq     = 4;
  localparam int DataW    = 8;
  localparam int BurstLen = 4;

  logic             r_clk = 1'b0;
  logic             rrst;
  logic [NReq-1:0]  req;
  logic [NReq-1:0]  gnt;
  logic             fifo_empty;
  logic             fifo_rd_req;
  logic [DataW-1:0] fifo_rdata;
  logic [DataW-1:0] rdata;
  logic [NReq-1:0]  rvalid;
  logic             busy;

  always #5 r_clk = ~r_clk;

  fifo_read_arbiter #(
    .NUM_REQ   (NReq),
    .DATA_WIDTH(DataW),
    .BURST_LEN (BurstLen)
  ) u_dut (
    .r_clk      (r_clk),
    .rrst       (rrst),
    .req        (req),
    .gnt        (gnt),
    .fifo_empty (fifo_empty),
    .fifo_rd_req(fifo_rd_req),
    .fifo_rdata (fifo_rdata),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .busy       (busy)
  );

  int n_cmp;
  int n_err;

  // Bench-side FIFO contents and reference model state.
  logic [DataW-1:0] fifo_q[$];
  int               owner;     // -1 when no burst is active
  int               reads;
  int               ptr;
  logic [NReq-1:0]  exp_rv;
  logic [DataW-1:0] exp_word;
  logic             pop;

  int               delivered[NReq];
  logic [NReq-1:0]  gnt_log[$];
  logic [NReq-1:0]  gnt_prev;
  logic [NReq-1:0]  exp_order[5];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NReq-1:0] log_at(input int i);
    if (i < gnt_log.size()) return gnt_log[i];
    return '0;
  endfunction

  task automatic push_words(input int n);
    repeat (n) fifo_q.push_back(DataW'($urandom));
  endtask

  // One clock cycle: check outputs against the model, advance the model, cross the edge.
  task automatic tick();
    logic [NReq-1:0] exp_gnt;
    logic            exp_rd;
    fifo_empty = (fifo_q.size() == 0);
    #1;
    exp_gnt = '0;
    exp_rd  = 1'b0;
    if (owner >= 0) begin
      exp_gnt[owner] = 1'b1;
      exp_rd = req[owner] && !fifo_empty && !rrst;
    end
    check_eq("gnt", 32'(gnt), 32'(exp_gnt));
    check_eq("busy", 32'(busy), 32'(owner >= 0));
    check_eq("fifo_rd_req", 32'(fifo_rd_req), 32'(exp_rd));
    check_eq("rvalid", 32'(rvalid), 32'(exp_rv));
    if (exp_rv != '0) check_eq("rdata", 32'(rdata), 32'(exp_word));

    for (int i = 0; i < NReq; i++) if (rvalid[i] === 1'b1) delivered[i]++;
    if (gnt_prev == '0 && gnt != '0) gnt_log.push_back(gnt);
    gnt_prev = gnt;

    pop = exp_rd;
    if (rrst) begin
      owner  = -1;
      reads  = 0;
      ptr    = 0;
      exp_rv = '0;
    end else begin
      exp_rv = exp_rd ? exp_gnt : '0;
      if (owner < 0) begin
        if (req != '0 && !fifo_empty) begin
          for (int i = 0; i < NReq; i++)
            if (owner < 0 && req[(ptr + i) % NReq]) owner = (ptr + i) % NReq;
          reads = 0;
        end
      end else begin
        if (exp_rd) reads++;
        if (!exp_rd || reads == BurstLen) begin
          ptr   = (owner + 1) % NReq;
          owner = -1;
        end
      end
    end

    @(posedge r_clk);
    #1;
    if (pop) begin
      exp_word   = fifo_q.pop_front();
      fifo_rdata = exp_word;
    end else begin
      fifo_rdata = DataW'($urandom);
    end
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    req  = '0;
    fifo_q.delete();
    tick();
    rrst = 1'b0;
    for (int i = 0; i < NReq; i++) delivered[i] = 0;
    gnt_log.delete();
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rrst       = 1'b1;
    req        = '0;
    fifo_rdata = '0;
    fifo_empty = 1'b1;
    owner      = -1;
    reads      = 0;
    ptr        = 0;
    exp_rv     = '0;
    exp_word   = '0;
    pop        = 1'b0;
    gnt_prev   = '0;
    exp_order  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    repeat (2) @(posedge r_clk);
    #1;

    // Single requester, 10 words: bursts of 4, 4, 2.
    do_reset();
    req = 4'b0010;
    push_words(10);
    repeat (20) tick();
    check_eq("single_words", 32'(delivered[1]), 32'd10);
    check_eq("single_grants", 32'(gnt_log.size()), 32'd3);

    // Round-robin with all requesting from reset.
    do_reset();
    req = 4'b1111;
    push_words(40);
    repeat (30) tick();
    for (int i = 0; i < 5; i++) check_eq("rr_order", 32'(log_at(i)), 32'(exp_order[i]));

    // Requester 2 drops after two reads; the next grant starts the search at 3.
    do_reset();
    push_words(20);
    req = 4'b0100;
    repeat (3) tick();
    req = 4'b0000;
    tick();
    check_eq("drop_words", 32'(delivered[2]), 32'd2);
    req = 4'b1111;
    repeat (3) tick();
    check_eq("drop_next_gnt", 32'(log_at(1)), 32'b1000);

    // FIFO runs dry after two words; no regrant until it refills.
    do_reset();
    push_words(2);
    req = 4'b0001;
    repeat (6) tick();
    check_eq("empty_grants", 32'(gnt_log.size()), 32'd1);
    push_words(4);
    repeat (8) tick();
    check_eq("refill_grants", 32'(gnt_log.size()), 32'd2);
    check_eq("refill_words", 32'(delivered[0]), 32'd6);

    // Reset in the cycle after the second read.
    do_reset();
    push_words(20);
    req = 4'b0001;
    repeat (3) tick();
    rrst = 1'b1;
    tick();
    rrst = 1'b0;
    req  = 4'b1000;
    repeat (5) tick();
    check_eq("post_reset_gnt", 32'(log_at(gnt_log.size() - 1)), 32'b1000);

    // Late arrival waits for the current burst and one idle cycle.
    do_reset();
    push_words(30);
    req = 4'b0001;
    repeat (2) tick();
    req = 4'b0011;
    repeat (10) tick();
    check_eq("late_first", 32'(log_at(0)), 32'b0001);
    check_eq("late_second", 32'(log_at(1)), 32'b0010);

    // Random traffic with occasional resets.
    do_reset();
    repeat (400) begin
      req = NReq'($urandom);
      if ($urandom_range(0, 3) == 0) push_words($urandom_range(1, 3));
      rrst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rrst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
